arm_multicycle_mainfsm: RTL and testbench

Main control state machine for the multicycle ARM core. It sequences fetch, decode, execute, memory and writeback steps over the shared ALU, memory port and register file.
Its unconditional RegW, MemW and NextPC requests feed condlogic, which gates them with the condition check. It also drives the datapath mux selects and ALU decoder enable directly.

---
 rtl/arm_multicycle_mainfsm.sv | 166 ++++++++++++++++
 tb/tb_arm_multicycle_mainfsm.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_mainfsm.sv
// Main control FSM for the multicycle ARM core: sequences fetch, decode, execute,
// memory and writeback over the shared ALU, memory port and register file.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read registers, pick instruction class
// MEMADR   | compute load/store address
// MEMRD    | read data memory
// MEMWB    | write loaded data to register file
// MEMWR    | write data memory
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | compute branch target
// UNKNOWN  | unsupported opcode, all controls idle
module arm_multicycle_mainfsm #(
    parameter bit UNKNOWN_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    // Only the I bit and the S/L bit steer the sequence.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.nextpc    = 1'b1;
            end
            DECODE: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            MEMADR: begin
                c.alusrcb   = 2'b01;
            end
            MEMRD: begin
                c.adrsrc    = 1'b1;
            end
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            MEMWR: begin
                c.adrsrc    = 1'b1;
                c.memw      = 1'b1;
            end
            EXECUTER: begin
                c.aluop     = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb   = 2'b01;
                c.aluop     = 1'b1;
            end
            ALUWB: begin
                c.regw      = 1'b1;
            end
            BRANCH: begin
                c.alusrca   = 2'b10;
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            UNKNOWN:  state_nxt = UNKNOWN_HALT ? UNKNOWN : FETCH;
            default:  state_nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they stay a pure function of State.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ctrl  <= ctrl_of(FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_of(state_nxt);
        end
    end

    assign IRWrite   = ctrl.irwrite;
    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign NextPC    = ctrl.nextpc;
    assign RegW      = ctrl.regw;
    assign MemW      = ctrl.memw;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.aluop;
    assign State     = state;

endmodule

// File: tb/tb_arm_multicycle_mainfsm.sv
// Bench for arm_multicycle_mainfsm: expected state sequences are queued per
// instruction and compared cycle by cycle; a second instance covers UNKNOWN_HALT=1.
module tb_arm_multicycle_mainfsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;

    logic       irw_m, adr_m, npc_m, rw_m, mw_m, br_m, aop_m;
    logic [1:0] sa_m, sb_m, rs_m;
    logic [3:0] st_m;
    logic       irw_h, adr_h, npc_h, rw_h, mw_h, br_h, aop_h;
    logic [1:0] sa_h, sb_h, rs_h;
    logic [3:0] st_h;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_h[$];

    always #5 clk = ~clk;

    arm_multicycle_mainfsm #(.UNKNOWN_HALT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(irw_m), .AdrSrc(adr_m), .ALUSrcA(sa_m), .ALUSrcB(sb_m),
        .ResultSrc(rs_m), .NextPC(npc_m), .RegW(rw_m), .MemW(mw_m),
        .Branch(br_m), .ALUOp(aop_m), .State(st_m)
    );

    arm_multicycle_mainfsm #(.UNKNOWN_HALT(1'b1)) u_halt (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(irw_h), .AdrSrc(adr_h), .ALUSrcA(sa_h), .ALUSrcB(sb_h),
        .ResultSrc(rs_h), .NextPC(npc_h), .RegW(rw_h), .MemW(mw_h),
        .Branch(br_h), .ALUOp(aop_h), .State(st_h)
    );

    wire [13:0] ctrl_m = {irw_m, adr_m, sa_m, sb_m, rs_m, npc_m, rw_m, mw_m, br_m, aop_m};
    wire [13:0] ctrl_h = {irw_h, adr_h, sa_h, sb_h, rs_h, npc_h, rw_h, mw_h, br_h, aop_h};

    // Fields: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp
    function automatic logic [13:0] model_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd1:    return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd2:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd3:    return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd4:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            4'd5:    return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            4'd6:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            4'd7:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            4'd8:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            4'd9:    return {1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            default: return 14'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [3:0] e;
        e = q_m.pop_front();
        chk({tag, " state"}, {28'd0, st_m}, {28'd0, e});
        chk({tag, " ctrl"}, {18'd0, ctrl_m}, {18'd0, model_ctrl(e)});
        e = q_h.pop_front();
        chk({tag, " halt state"}, {28'd0, st_h}, {28'd0, e});
        chk({tag, " halt ctrl"}, {18'd0, ctrl_h}, {18'd0, model_ctrl(e)});
    endtask

    // Called at a negedge with both instances about to begin the sequence.
    // seq nibble i is the expected state in cycle i; from cycle scr on Op/Funct are scrambled.
    task automatic run(input string tag, input logic [1:0] op, input logic [5:0] funct,
                       input int n, input logic [19:0] seq_m, input logic [19:0] seq_h,
                       input int scr);
        Op    = op;
        Funct = funct;
        for (int i = 0; i < n; i++) begin
            q_m.push_back(seq_m[4*i +: 4]);
            q_h.push_back(seq_h[4*i +: 4]);
        end
        for (int i = 0; i < n; i++) begin
            if (scr > 0 && i >= scr) begin
                Op    = 2'($urandom_range(0, 3));
                Funct = 6'($urandom_range(0, 63));
            end
            pop_check(tag);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state", {28'd0, st_m}, 32'd0);
        chk("reset ctrl", {18'd0, ctrl_m}, {18'd0, model_ctrl(4'd0)});
        chk("reset halt state", {28'd0, st_h}, 32'd0);
        reset = 1'b1;

        run("add",  2'b00, 6'b001000, 4, 20'h08610, 20'h08610, 2);
        run("adds", 2'b00, 6'b101001, 4, 20'h08710, 20'h08710, 0);
        run("ldr",  2'b01, 6'b011001, 5, 20'h43210, 20'h43210, 3);
        run("str",  2'b01, 6'b011000, 4, 20'h05210, 20'h05210, 3);
        run("b",    2'b10, 6'b000000, 3, 20'h00910, 20'h00910, 0);
        run("und",  2'b11, 6'b000000, 3, 20'h00A10, 20'h00A10, 0);
        run("b2",   2'b10, 6'b000000, 3, 20'h00910, 20'h00AAA, 0);

        // Load interrupted by reset while in MEMRD.
        run("ldr_pre", 2'b01, 6'b011001, 3, 20'h00210, 20'h00AAA, 0);
        chk("mid state before reset", {28'd0, st_m}, 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("async reset state", {28'd0, st_m}, 32'd0);
        chk("async reset ctrl", {18'd0, ctrl_m}, {18'd0, model_ctrl(4'd0)});
        chk("async reset irwrite", {31'd0, irw_m}, 32'd1);
        chk("async reset halt state", {28'd0, st_h}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("held reset state", {28'd0, st_m}, 32'd0);
        chk("held reset regw", {31'd0, rw_m}, 32'd0);
        reset = 1'b1;
        run("post_reset", 2'b10, 6'b000000, 4, 20'h00910, 20'h00910, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
